// File: rtl/cmos_rgb565_packer.sv
// cmos_rgb565_packer
// Packs the camera's windowed 8-bit DVP byte stream into RGB565 pixels,
// expands them to RGB888 and produces the linear frame-buffer write address
// together with frame/line markers. Malformed lines (unpaired byte, wrong
// pixel count) and pixels beyond the end of the frame raise sticky flags.

module cmos_rgb565_packer #(
  parameter int H_ACTIVE   = 1280,
  parameter int V_ACTIVE   = 720,
  parameter int ADDR_W     = 20,
  parameter bit SWAP_BYTES = 1'b0
) (
  input  logic              iCLK,
  input  logic              iRST_N,
  input  logic [7:0]        iDATA,
  input  logic              iDVAL,
  input  logic              iSYNC,
  output logic [23:0]       oRGB,
  output logic              oPIX_VAL,
  output logic [ADDR_W-1:0] oADDR,
  output logic              oSOF,
  output logic              oEOF,
  output logic              oEOL,
  output logic              oBYTE_ERR,
  output logic              oLINE_ERR,
  output logic              oOVF
);

  localparam int TOTAL = H_ACTIVE * V_ACTIVE;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(TOTAL - 1);

  // Line pixel counter has one spare bit so over-long lines are still seen
  // as "not H_ACTIVE"; it saturates rather than wrapping back to a match.
  localparam int LPIX_W = $clog2(H_ACTIVE + 1) + 1;
  localparam logic [LPIX_W-1:0] LPIX_MAX = '1;
  localparam logic [LPIX_W-1:0] H_CNT    = LPIX_W'(H_ACTIVE);

  localparam int LINE_W = $clog2(V_ACTIVE + 1);
  localparam logic [LINE_W-1:0] V_CNT = LINE_W'(V_ACTIVE);

  // Byte-pairing FSM: IDLE until the first frame start, then alternates
  // between waiting for the first (HI) and second (LO) byte of a pixel.
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_HI   = 2'd1;
  localparam logic [1:0] ST_LO   = 2'd2;

  logic [1:0]        state;
  logic [7:0]        hi_byte;
  logic              dval_d;
  logic [ADDR_W-1:0] pix_addr;
  logic              frame_done;
  logic [LPIX_W-1:0] line_pix;
  logic [LINE_W-1:0] line_cnt;

  logic              line_end;
  logic              pair_done;
  logic              accept_pix;
  logic              drop_pix;
  logic [15:0]       pix_word;
  logic [4:0]        r5;
  logic [5:0]        g6;
  logic [4:0]        b5;
  logic [23:0]       rgb888;

  // Falling edge of the byte-valid marks the end of a line; ignored before
  // the first frame start so stray blanking after reset is silent.
  assign line_end   = dval_d & ~iDVAL & (state != ST_IDLE);

  // A pixel completes when the second byte arrives; a frame start in the
  // same cycle takes priority and turns that byte into a new HI byte.
  assign pair_done  = (state == ST_LO) & iDVAL & ~iSYNC;
  assign accept_pix = pair_done & ~frame_done;
  assign drop_pix   = pair_done &  frame_done;

  assign pix_word = SWAP_BYTES ? {iDATA, hi_byte} : {hi_byte, iDATA};
  assign r5       = pix_word[15:11];
  assign g6       = pix_word[10:5];
  assign b5       = pix_word[4:0];

  // Replicating the top bits maps full-scale 565 codes onto 8'hFF exactly.
  assign rgb888   = {r5, r5[4:2], g6, g6[5:4], b5, b5[4:2]};

  // Byte-pairing state machine and HI-byte holding register.
  // NOTE: every register here is written with <= so all of them update from
  // the same pre-edge values; a blocking = would let later lines see new ones.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state   <= ST_IDLE;
      hi_byte <= '0;
      dval_d  <= 1'b0;
    end else begin
      dval_d <= iDVAL;
      if (iSYNC) begin
        if (iDVAL) begin
          hi_byte <= iDATA;
          state   <= ST_LO;
        end else begin
          state   <= ST_HI;
        end
      end else begin
        case (state)
          ST_HI: begin
            if (iDVAL) begin
              hi_byte <= iDATA;
              state   <= ST_LO;
            end
          end
          // Either the pair completes, or the line ended mid-pair and the
          // pending byte is discarded; both resume at the HI byte.
          ST_LO:   state <= ST_HI;
          ST_IDLE: state <= ST_IDLE;
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  // Linear frame address; freezes once the last pixel of the frame is out.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      pix_addr   <= '0;
      frame_done <= 1'b0;
    end else if (iSYNC) begin
      pix_addr   <= '0;
      frame_done <= 1'b0;
    end else if (accept_pix) begin
      if (pix_addr == LAST_ADDR) begin
        frame_done <= 1'b1;
      end else begin
        pix_addr <= pix_addr + 1'b1;
      end
    end
  end

  // Output pixel register: strobes for one cycle, data/address hold between.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      oRGB     <= '0;
      oADDR    <= '0;
      oPIX_VAL <= 1'b0;
      oSOF     <= 1'b0;
      oEOF     <= 1'b0;
      oEOL     <= 1'b0;
    end else begin
      oPIX_VAL <= accept_pix;
      oSOF     <= accept_pix & (pix_addr == '0);
      oEOF     <= accept_pix & (pix_addr == LAST_ADDR);
      oEOL     <= line_end;
      if (accept_pix) begin
        oRGB  <= rgb888;
        oADDR <= pix_addr;
      end
    end
  end

  // Per-line pixel count (cleared at every line end) and saturating line count.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      line_pix <= '0;
      line_cnt <= '0;
    end else if (iSYNC) begin
      line_pix <= '0;
      line_cnt <= '0;
    end else if (line_end) begin
      line_pix <= '0;
      if (line_cnt != V_CNT) begin
        line_cnt <= line_cnt + 1'b1;
      end
    end else if (pair_done && (line_pix != LPIX_MAX)) begin
      line_pix <= line_pix + 1'b1;
    end
  end

  // Sticky error flags; only a frame start or reset clears them.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      oBYTE_ERR <= 1'b0;
      oLINE_ERR <= 1'b0;
      oOVF      <= 1'b0;
    end else if (iSYNC) begin
      oBYTE_ERR <= 1'b0;
      oLINE_ERR <= 1'b0;
      oOVF      <= 1'b0;
    end else begin
      if (line_end && (state == ST_LO)) begin
        oBYTE_ERR <= 1'b1;
      end
      if (line_end && (line_pix != H_CNT)) begin
        oLINE_ERR <= 1'b1;
      end
      if (drop_pix) begin
        oOVF <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_cmos_rgb565_packer.sv
// tb_cmos_rgb565_packer
// Directed bench for the RGB565 packer. A reduced 32x6 frame keeps a full
// frame (and its overflow) short; every expected pixel is queued when its
// second byte is driven and compared when the strobe appears.

module tb_cmos_rgb565_packer;

  localparam int H     = 32;
  localparam int V     = 6;
  localparam int AW    = 8;
  localparam int TOTAL = H * V;

  typedef struct packed {
    logic [23:0]   rgb;
    logic [AW-1:0] addr;
    logic          sof;
    logic          eof;
  } pix_t;

  logic          clk;
  logic          rst_n;
  logic [7:0]    data;
  logic          dval;
  logic          sync;
  logic [23:0]   rgb;
  logic          pix_val;
  logic [AW-1:0] addr;
  logic          sof;
  logic          eof;
  logic          eol;
  logic          byte_err;
  logic          line_err;
  logic          ovf;

  pix_t exp_q[$];
  int   checks   = 0;
  int   errors   = 0;
  int   eol_seen = 0;
  int   eol_exp  = 0;
  int   exp_addr = 0;
  bit   armed    = 1'b0;
  bit   prev_dv  = 1'b0;

  cmos_rgb565_packer #(
    .H_ACTIVE  (H),
    .V_ACTIVE  (V),
    .ADDR_W    (AW),
    .SWAP_BYTES(1'b0)
  ) dut (
    .iCLK     (clk),
    .iRST_N   (rst_n),
    .iDATA    (data),
    .iDVAL    (dval),
    .iSYNC    (sync),
    .oRGB     (rgb),
    .oPIX_VAL (pix_val),
    .oADDR    (addr),
    .oSOF     (sof),
    .oEOF     (eof),
    .oEOL     (eol),
    .oBYTE_ERR(byte_err),
    .oLINE_ERR(line_err),
    .oOVF     (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [23:0] expand(input logic [15:0] w);
    int r, g, b;
    r = int'(w[15:11]);
    g = int'(w[10:5]);
    b = int'(w[4:0]);
    return {8'((r << 3) | (r >> 2)), 8'((g << 2) | (g >> 4)), 8'((b << 3) | (b >> 2))};
  endfunction

  // One clock of stimulus; inputs change 1 time unit after the active edge.
  task automatic drive(input logic [7:0] d, input logic dv, input logic sy);
    data = d;
    dval = dv;
    sync = sy;
    if (armed && prev_dv && !dv) eol_exp++;
    prev_dv = dv;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(8'h00, 1'b0, 1'b0);
  endtask

  task automatic push_exp(input logic [23:0] c);
    pix_t p;
    if (armed && exp_addr < TOTAL) begin
      p.rgb  = c;
      p.addr = AW'(exp_addr);
      p.sof  = (exp_addr == 0);
      p.eof  = (exp_addr == TOTAL - 1);
      exp_q.push_back(p);
      exp_addr++;
    end
  endtask

  task automatic pixel_exp(input logic [15:0] w, input logic [23:0] c);
    drive(w[15:8], 1'b1, 1'b0);
    push_exp(c);
    drive(w[7:0], 1'b1, 1'b0);
  endtask

  task automatic pixel(input logic [15:0] w);
    pixel_exp(w, expand(w));
  endtask

  task automatic rand_pixels(input int n);
    logic [15:0] w;
    for (int i = 0; i < n; i++) begin
      w = 16'($urandom);
      pixel(w);
    end
  endtask

  task automatic red_pixels(input int n);
    for (int i = 0; i < n; i++) pixel_exp(16'hF800, 24'hFF0000);
  endtask

  task automatic do_sync;
    drive(8'h00, 1'b0, 1'b1);
    armed    = 1'b1;
    exp_addr = 0;
  endtask

  // Output monitor: away from the active edge, pop and compare each strobe.
  always @(negedge clk) begin
    pix_t p;
    if (eol) eol_seen++;
    if (pix_val) begin
      if (exp_q.size() == 0) begin
        check("unexpected_pix", 32'(pix_val), 32'd0);
      end else begin
        p = exp_q.pop_front();
        check("pix_rgb",  32'(rgb),  32'(p.rgb));
        check("pix_addr", 32'(addr), 32'(p.addr));
        check("pix_sof",  32'(sof),  32'(p.sof));
        check("pix_eof",  32'(eof),  32'(p.eof));
      end
    end
  end

  initial begin
    logic [15:0] w;
    rst_n = 1'b0;
    data  = 8'h00;
    dval  = 1'b0;
    sync  = 1'b0;
    #12;
    check("rst_rgb",      32'(rgb),      32'd0);
    check("rst_pix_val",  32'(pix_val),  32'd0);
    check("rst_addr",     32'(addr),     32'd0);
    check("rst_eol",      32'(eol),      32'd0);
    check("rst_flags",    32'({sof, eof, byte_err, line_err, ovf}), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Bytes before the first frame start produce nothing.
    red_pixels(2);
    idle(2);
    check("pre_sync_eol", 32'(eol_seen), 32'd0);

    // Two full red lines: addresses 0..2H-1, SOF on the first.
    do_sync;
    red_pixels(H);
    idle(2);
    red_pixels(H);
    idle(2);
    check("t1_eol_count", 32'(eol_seen), 32'd2);
    check("t1_byte_err",  32'(byte_err), 32'd0);
    check("t1_line_err",  32'(line_err), 32'd0);
    check("t1_ovf",       32'(ovf),      32'd0);
    check("t1_q_empty",   32'(exp_q.size()), 32'd0);

    // Pure green then pure blue, each visible one cycle after its 2nd byte.
    pixel_exp(16'h07E0, 24'h00FF00);
    check("t2_green_val", 32'(pix_val), 32'd1);
    check("t2_green_rgb", 32'(rgb),     32'h00FF00);
    pixel_exp(16'h001F, 24'h0000FF);
    check("t2_blue_val",  32'(pix_val), 32'd1);
    check("t2_blue_rgb",  32'(rgb),     32'h0000FF);
    rand_pixels(H - 2);
    idle(2);
    check("t2_line_err",  32'(line_err), 32'd0);

    // Odd byte count: H pixels plus a stray byte.
    rand_pixels(H);
    drive(8'h5A, 1'b1, 1'b0);
    idle(2);
    check("t3_byte_err", 32'(byte_err), 32'd1);
    check("t3_line_err", 32'(line_err), 32'd0);
    pixel_exp(16'hF800, 24'hFF0000);
    check("t3_next_addr", 32'(addr), 32'(4 * H));
    check("t3_next_rgb",  32'(rgb),  32'hFF0000);
    red_pixels(H - 1);
    idle(2);

    // Short line flags a pixel-count error; the rest completes the frame.
    rand_pixels(10);
    idle(2);
    check("t4_line_err", 32'(line_err), 32'd1);
    rand_pixels(TOTAL - 5 * H - 11);
    pixel_exp(16'h1234, expand(16'h1234));
    check("t4_eof",      32'(eof),  32'd1);
    check("t4_eof_addr", 32'(addr), 32'(TOTAL - 1));
    idle(2);
    check("t4_ovf_before", 32'(ovf), 32'd0);
    pixel(16'hABCD);
    check("t4_extra_suppressed", 32'(pix_val), 32'd0);
    idle(2);
    check("t4_ovf",      32'(ovf),      32'd1);
    check("t4_byte_err", 32'(byte_err), 32'd1);

    // New frame clears the sticky flags and restarts at address 0.
    do_sync;
    check("t4_sync_ovf",      32'(ovf),      32'd0);
    check("t4_sync_byte_err", 32'(byte_err), 32'd0);
    check("t4_sync_line_err", 32'(line_err), 32'd0);
    pixel_exp(16'hF800, 24'hFF0000);
    check("t4_sof",      32'(sof),  32'd1);
    check("t4_sof_addr", 32'(addr), 32'd0);

    // Frame start while a byte is pending: that byte becomes the new HI.
    rand_pixels(3);
    drive(8'hAB, 1'b1, 1'b0);
    drive(8'h12, 1'b1, 1'b1);
    exp_addr = 0;
    push_exp(expand(16'h1234));
    drive(8'h34, 1'b1, 1'b0);
    check("t5_addr", 32'(addr), 32'd0);
    check("t5_sof",  32'(sof),  32'd1);
    check("t5_rgb",  32'(rgb),  32'(expand(16'h1234)));
    rand_pixels(H - 1);
    idle(2);
    check("t5_line_err", 32'(line_err), 32'd0);
    check("t5_byte_err", 32'(byte_err), 32'd0);

    // Mid-frame reset: everything drops to 0 without waiting for a clock.
    rand_pixels(5);
    idle(2);
    check("t6_line_err_set", 32'(line_err), 32'd1);
    pixel(16'hFFFF);
    check("t6_pre_rgb", 32'(rgb), 32'hFFFFFF);
    @(negedge clk);
    #1;
    rst_n   = 1'b0;
    dval    = 1'b0;
    prev_dv = 1'b0;
    armed   = 1'b0;
    #1;
    check("t6_rgb",     32'(rgb),     32'd0);
    check("t6_addr",    32'(addr),    32'd0);
    check("t6_pix_val", 32'(pix_val), 32'd0);
    check("t6_flags",   32'({sof, eof, eol, byte_err, line_err, ovf}), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    red_pixels(3);
    idle(2);
    do_sync;
    w = 16'h8410;
    pixel(w);
    check("t6_resync_addr", 32'(addr), 32'd0);
    check("t6_resync_sof",  32'(sof),  32'd1);
    idle(2);

    check("final_q_empty",  32'(exp_q.size()), 32'd0);
    check("final_eol_count", 32'(eol_seen), 32'(eol_exp));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
